// File: rtl/chess_pkg.sv
// Shared encodings for the chess-clock turn controller: FSM state codes,
// winner codes and the default prescaler divide ratio.
package chess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10
  } winner_e;

  localparam int unsigned TICK_DIV_DEFAULT = 4;

  function automatic logic is_run(input state_e s);
    return (s == ST_RUN_A) || (s == ST_RUN_B);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-TICK_DIV tick generator shared by both player counter chains.
// Counts only while enabled, holds otherwise; sclr_i wins over counting.
module tick_prescaler
  import chess_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sclr_i,
  output logic impulse_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by en_i so the tick can never escape outside a running turn.
  assign impulse_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/turn_control.sv
// Chess-clock turn sequencer: button edge detect, game FSM, winner latch and
// the shared count tick / clear for both player counter chains.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no game; waiting for START to begin with player A
// RUN_A    | player A's clock running
// RUN_B    | player B's clock running
// PAUSE    | both clocks frozen; saved_b_q remembers who resumes
// DONE     | a chain timed out; WINNER held until START
module turn_control
  import chess_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       btn_a_i,
  input  logic       btn_b_i,
  input  logic       btn_start_i,
  input  logic       timeout_a_i,
  input  logic       timeout_b_i,
  output logic       ce_a_o,
  output logic       ce_b_o,
  output logic       impulse_o,
  output logic       cnt_clr_o,
  output logic [2:0] state_o,
  output logic [1:0] winner_o
);

  state_e     state_q, state_d;
  logic [1:0] winner_q, winner_d;
  logic       saved_b_q, saved_b_d;
  logic       prev_a_q, prev_b_q, prev_s_q;

  logic edge_a, edge_b, edge_s;
  logic start_clr, presc_clr, run;

  assign edge_a = btn_a_i & ~prev_a_q;
  assign edge_b = btn_b_i & ~prev_b_q;
  assign edge_s = btn_start_i & ~prev_s_q;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    saved_b_d = saved_b_q;
    start_clr = 1'b0;
    presc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_s) begin
          state_d   = ST_RUN_A;
          winner_d  = WIN_NONE;
          start_clr = 1'b1;
          presc_clr = 1'b1;
        end
      end
      ST_RUN_A: begin
        if (timeout_a_i) begin
          state_d  = ST_DONE;
          winner_d = WIN_B;
        end else if (edge_s) begin
          state_d   = ST_PAUSE;
          saved_b_d = 1'b0;
        end else if (edge_a) begin
          state_d   = ST_RUN_B;
          presc_clr = 1'b1;
        end
      end
      ST_RUN_B: begin
        if (timeout_b_i) begin
          state_d  = ST_DONE;
          winner_d = WIN_A;
        end else if (edge_s) begin
          state_d   = ST_PAUSE;
          saved_b_d = 1'b1;
        end else if (edge_b) begin
          state_d   = ST_RUN_A;
          presc_clr = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (edge_s) begin
          state_d = saved_b_q ? ST_RUN_B : ST_RUN_A;
        end
      end
      ST_DONE: begin
        if (edge_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge history resets high so a button held through reset is not a press.
  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      state_q   <= ST_IDLE;
      winner_q  <= WIN_NONE;
      saved_b_q <= 1'b0;
      prev_a_q  <= 1'b1;
      prev_b_q  <= 1'b1;
      prev_s_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      saved_b_q <= saved_b_d;
      prev_a_q  <= btn_a_i;
      prev_b_q  <= btn_b_i;
      prev_s_q  <= btn_start_i;
    end
  end

  assign run = is_run(state_q) && clr_i;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (clr_i),
    .en_i     (run),
    .sclr_i   (presc_clr),
    .impulse_o(impulse_o)
  );

  assign ce_a_o    = (state_q == ST_RUN_A);
  assign ce_b_o    = (state_q == ST_RUN_B);
  assign cnt_clr_o = ~clr_i | start_clr;
  assign state_o   = state_q;
  assign winner_o  = winner_q;

endmodule

// File: tb/tb_turn_control.sv
// Bench for turn_control: a per-cycle reference model feeds a scoreboard of
// expected outputs, plus directed checks on tick spacing and game outcomes.
module tb_turn_control;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       clr, btn_a, btn_b, btn_s, to_a, to_b;
  logic       ce_a_o, ce_b_o, impulse_o, cnt_clr_o;
  logic [2:0] state_o;
  logic [1:0] winner_o;

  turn_control #(
    .TICK_DIV(TD)
  ) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .btn_a_i    (btn_a),
    .btn_b_i    (btn_b),
    .btn_start_i(btn_s),
    .timeout_a_i(to_a),
    .timeout_b_i(to_b),
    .ce_a_o     (ce_a_o),
    .ce_b_o     (ce_b_o),
    .impulse_o  (impulse_o),
    .cnt_clr_o  (cnt_clr_o),
    .state_o    (state_o),
    .winner_o   (winner_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ce_a;
    logic       ce_b;
    logic       imp;
    logic       cclr;
    logic [1:0] win;
  } vec_t;

  vec_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc_n  = 0;
  int   clr_cnt = 0;
  int   imp_q[$];

  int   m_st = 0, m_cnt = 0, m_win = 0;
  bit   m_saved_b = 0, m_pa = 1, m_pb = 1, m_ps = 1, m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score this cycle's outputs, advance the model.
  task automatic cyc(input bit c, input bit s, input bit a, input bit b,
                     input bit xa, input bit xb);
    vec_t e, o;
    bit   ea, eb, es, run, pclr;
    int   nst;
    @(negedge clk);
    clr = c; btn_s = s; btn_a = a; btn_b = b; to_a = xa; to_b = xb;
    ea  = a && !m_pa;
    eb  = b && !m_pb;
    es  = s && !m_ps;
    run = c && (m_st == 1 || m_st == 2);
    e.st   = 3'(m_st);
    e.ce_a = (m_st == 1);
    e.ce_b = (m_st == 2);
    e.imp  = run && (m_cnt == TD - 1);
    e.cclr = !c || (m_st == 0 && es);
    e.win  = 2'(m_win);
    if (m_valid) sb_q.push_back(e);
    #1;
    if (impulse_o === 1'b1) imp_q.push_back(cyc_n);
    if (cnt_clr_o === 1'b1 && c) clr_cnt++;
    if (sb_q.size() > 0) begin
      o = {state_o, ce_a_o, ce_b_o, impulse_o, cnt_clr_o, winner_o};
      e = sb_q.pop_front();
      chk($sformatf("cyc%0d", cyc_n), 32'(o), 32'(e));
    end
    cyc_n++;
    if (!c) begin
      m_st = 0; m_win = 0; m_cnt = 0; m_saved_b = 0;
      m_pa = 1; m_pb = 1; m_ps = 1; m_valid = 1;
    end else begin
      nst  = m_st;
      pclr = 0;
      case (m_st)
        0: if (es) begin nst = 1; m_win = 0; pclr = 1; end
        1: if (xa) begin nst = 4; m_win = 2; end
           else if (es) begin nst = 3; m_saved_b = 0; end
           else if (ea) begin nst = 2; pclr = 1; end
        2: if (xb) begin nst = 4; m_win = 1; end
           else if (es) begin nst = 3; m_saved_b = 1; end
           else if (eb) begin nst = 1; pclr = 1; end
        3: if (es) nst = m_saved_b ? 2 : 1;
        4: if (es) nst = 0;
        default: nst = 0;
      endcase
      if (pclr) m_cnt = 0;
      else if (run) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      m_st = nst;
      m_pa = a; m_pb = b; m_ps = s;
    end
  endtask

  int base;

  initial begin
    clr = 1'b0; btn_a = 1'b0; btn_b = 1'b0; btn_s = 1'b0; to_a = 1'b0; to_b = 1'b0;

    // Reset with START held, then release and press once.
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_cnt_clr", 32'(cnt_clr_o), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_state", 32'(state_o), 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("held_no_start", 32'(state_o), 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    clr_cnt = 0;
    cyc(1, 1, 0, 0, 0, 0);
    chk("start_cnt_clr", 32'(cnt_clr_o), 1);

    // Twelve RUN_A cycles: three ticks, four apart.
    imp_q.delete();
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("ce_a_run", 32'(ce_a_o), 1);
    chk("imp_12cyc", imp_q.size(), 3);
    chk("imp_space1", (imp_q.size() >= 3) ? imp_q[1] - imp_q[0] : -1, 4);
    chk("imp_space2", (imp_q.size() >= 3) ? imp_q[2] - imp_q[1] : -1, 4);
    chk("cnt_clr_once", clr_cnt, 1);

    // Switch to B after two counts; first tick on the 4th RUN_B cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    imp_q.delete();
    base = cyc_n;
    cyc(1, 0, 0, 0, 0, 0);
    chk("run_b", 32'(state_o), 2);
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("sw_first_imp", (imp_q.size() > 0) ? imp_q[0] - base : -1, 3);
    chk("sw_b_ignores_a", 32'(state_o), 2);

    // Pause from RUN_B; nothing ticks, inputs ignored, resume from held count.
    cyc(1, 1, 0, 0, 0, 0);
    imp_q.delete();
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pause_state", 32'(state_o), 3);
    chk("pause_no_imp", imp_q.size(), 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("resume_b", 32'(state_o), 2);
    chk("resume_imp", 32'(impulse_o), 1);

    // Back to A, then timeout and A press together.
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_a_done", 32'(state_o), 4);
    chk("to_a_winner", 32'(winner_o), 2);
    chk("done_ce", 32'({ce_a_o, ce_b_o}), 0);
    cyc(1, 0, 1, 1, 1, 1);

    // DONE -> IDLE keeps winner until the next game starts.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("idle_win_held", 32'(winner_o), 2);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("new_game_win", 32'(winner_o), 0);

    // START beats a player edge; then B times out together with START.
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("prio_pause", 32'(state_o), 3);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("resume_a", 32'(state_o), 1);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_b_winner", 32'(winner_o), 1);

    // Reset while the tick is due: no tick in the reset cycle.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_no_imp", 32'(impulse_o), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_mid_idle", 32'(state_o), 0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 40) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 25) == 0, $urandom_range(0, 25) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/turn_control.md
TURN_CONTROL -- requirements
Module: turn_control

Interface
REQ-001 Parameter TICK_DIV, default 4, CLK cycles per IMPULSE tick (range 2..2^16).
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 CLR  in  1  reset, synchronous, active-low.
REQ-004 BTN_A  in  1  player A button; debounced, synchronous to CLK, level.
REQ-005 BTN_B  in  1  player B button; same conditioning as BTN_A.
REQ-006 BTN_START  in  1  start/pause/new-game button; same conditioning.
REQ-007 TIMEOUT_A  in  1  player A counter chain exhausted (final-stage OVERFLOW), level.
REQ-008 TIMEOUT_B  in  1  player B counter chain exhausted, level.
REQ-009 CE_A  out  1  enable for player A counter chain.
REQ-010 CE_B  out  1  enable for player B counter chain.
REQ-011 IMPULSE  out  1  one-cycle count tick shared by both chains.
REQ-012 CNT_CLR  out  1  one-cycle active-high clear for both chains.
REQ-013 STATE  out  3  current FSM state code.
REQ-014 WINNER  out  2  00 none, 01 A, 10 B.

Function
REQ-015 Button edge = current sample 1 AND previous sample 0; previous-sample registers per button.
REQ-016 FSM states: IDLE=0, RUN_A=1, RUN_B=2, PAUSE=3, DONE=4; codes 5..7 SHALL return to IDLE next cycle.
REQ-017 IDLE: START edge -> RUN_A, CNT_CLR pulse same cycle as transition, WINNER<=00.
REQ-018 RUN_A: TIMEOUT_A=1 -> DONE, WINNER<=10; else START edge -> PAUSE; else BTN_A edge -> RUN_B; BTN_B ignored.
REQ-019 RUN_B: TIMEOUT_B=1 -> DONE, WINNER<=01; else START edge -> PAUSE; else BTN_B edge -> RUN_A; BTN_A ignored.
REQ-020 Priority within a cycle: timeout > START edge > player button edge.
REQ-021 PAUSE: START edge -> player active before pause (one saved bit); player buttons and timeouts ignored.
REQ-022 DONE: START edge -> IDLE; all else ignored; WINNER held.
REQ-023 Latency: edge sampled at clock k -> new STATE, CE_A/CE_B valid after clock k (one cycle).
REQ-024 CE_A=1 iff STATE=RUN_A; CE_B=1 iff STATE=RUN_B; never both 1.
REQ-025 Prescaler counts 0..TICK_DIV-1 only in RUN_A/RUN_B; IMPULSE=1 for the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-026 Prescaler holds value in PAUSE; clears to 0 on IDLE->RUN_A and on every player switch.
REQ-027 IMPULSE SHALL be 0 whenever STATE is not RUN_A/RUN_B.
REQ-028 Prescaler width = ceil(log2(TICK_DIV)); no wrap beyond TICK_DIV-1.

Reset
REQ-029 CLR=0 at a clock edge: STATE=IDLE, WINNER=00, CE_A=CE_B=IMPULSE=0, prescaler=0, saved player=A.
REQ-030 CNT_CLR SHALL be 1 while CLR=0 so counter chains clear with this block.
REQ-031 Previous-sample registers reset to 1, so a button held through reset produces no edge.
REQ-032 Reset mid-game SHALL abort to IDLE with no IMPULSE in the reset cycle.

Structure
REQ-033 Package chess_pkg holds state codes, WINNER codes and default TICK_DIV.
REQ-034 Sub-module tick_prescaler (inputs EN, SCLR; output IMPULSE) holds the divider; FSM and edge detect stay in turn_control.

Verification
REQ-035 Reset with BTN_START held, release, press -> single IDLE->RUN_A, CNT_CLR one cycle, CE_A=1.
REQ-036 TICK_DIV=4, RUN_A 12 cycles -> IMPULSE exactly 3 pulses, 4 cycles apart.
REQ-037 RUN_A, BTN_A edge after 2 prescaler counts -> RUN_B, prescaler 0, next IMPULSE 4 cycles later.
REQ-038 RUN_B, START edge -> PAUSE, no IMPULSE; START edge -> RUN_B, prescaler resumes from held value.
REQ-039 RUN_A, TIMEOUT_A and BTN_A edge same cycle -> DONE, WINNER=10, CE_A=CE_B=0.
REQ-040 DONE, START edge -> IDLE, WINNER=00 only on next START edge into RUN_A.
